// File: rtl/packet_tx_sched.sv
// Frame-rate packet scheduler: snapshots the assembled game-state packet on
// each frame tick or software request and streams it out byte 0 first over a
// valid/ready handshake, counting completed frames and dropped triggers.
module packet_tx_sched #(
    parameter int PACKET_BYTES  = 22,
    parameter int PERIOD_CYCLES = 1666666
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      send_req,
    input  logic [8*PACKET_BYTES-1:0] packet,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               frames_sent,
    output logic [7:0]                overrun_cnt
);

    localparam int CW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int IW = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PACKET_BYTES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [CW-1:0]             periodCnt_q, periodCnt_d;
    logic [0:0]                state_q, state_d;
    logic [IW-1:0]             byteIdx_q, byteIdx_d;
    logic [8*PACKET_BYTES-1:0] snap_q, snap_d;
    logic                      frameDone_q, frameDone_d;
    logic [15:0]               framesSent_q, framesSent_d;
    logic [7:0]                overrun_q, overrun_d;

    logic tick;
    logic trigger;
    logic xfer;
    logic lastXfer;

    // Period counter: free-runs while enabled, parked at zero otherwise.
    always_comb begin
        tick        = enable && (periodCnt_q == CNT_LAST);
        periodCnt_d = '0;
        if (enable && !tick) begin
            periodCnt_d = periodCnt_q + 1'b1;
        end
    end

    // Transfer scheduling: the snapshot shifts right so byte 0 of what is left
    // is always the byte on the wire.
    always_comb begin
        trigger      = tick || send_req;
        xfer         = (state_q == SEND) && tx_ready;
        lastXfer     = xfer && (byteIdx_q == IDX_LAST);
        state_d      = state_q;
        byteIdx_d    = byteIdx_q;
        snap_d       = snap_q;
        frameDone_d  = 1'b0;
        framesSent_d = framesSent_q;
        overrun_d    = overrun_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d   = SEND;
                    snap_d    = packet;
                    byteIdx_d = '0;
                end
            end
            SEND: begin
                if (trigger && (overrun_q != 8'hFF)) begin
                    overrun_d = overrun_q + 8'd1;
                end
                if (xfer) begin
                    snap_d = snap_q >> 8;
                    if (lastXfer) begin
                        state_d      = IDLE;
                        frameDone_d  = 1'b1;
                        framesSent_d = framesSent_q + 16'd1;
                    end else begin
                        byteIdx_d = byteIdx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset also abandons a partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            periodCnt_q  <= '0;
            state_q      <= IDLE;
            byteIdx_q    <= '0;
            snap_q       <= '0;
            frameDone_q  <= 1'b0;
            framesSent_q <= '0;
            overrun_q    <= '0;
        end else begin
            periodCnt_q  <= periodCnt_d;
            state_q      <= state_d;
            byteIdx_q    <= byteIdx_d;
            snap_q       <= snap_d;
            frameDone_q  <= frameDone_d;
            framesSent_q <= framesSent_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx_data     = snap_q[7:0];
    assign tx_valid    = (state_q == SEND);
    assign busy        = (state_q == SEND);
    assign frame_done  = frameDone_q;
    assign frames_sent = framesSent_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_packet_tx_sched.sv
// Scoreboard bench for packet_tx_sched: expected bytes are queued when a frame
// is triggered and compared against bytes observed crossing the handshake.
module tb_packet_tx_sched;

    localparam int PB  = 22;
    localparam int PER = 40;
    localparam int PW  = 8 * PB;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          send_req;
    logic [PW-1:0] packet;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frames_sent;
    logic [7:0]    overrun_cnt;

    int errors = 0;
    int checks = 0;
    int expFrames;
    int expOverrun;
    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];

    packet_tx_sched #(
        .PACKET_BYTES (PB),
        .PERIOD_CYCLES(PER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .send_req   (send_req),
        .packet     (packet),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .frames_sent(frames_sent),
        .overrun_cnt(overrun_cnt)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Record every byte that will be accepted at the coming rising edge
    always @(negedge clk) begin
        if (!rst && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            gotQ.push_back(tx_data);
        end
    end

    function automatic logic [PW-1:0] makePkt(input logic [7:0] seed);
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < PB; k++) begin
            if (k == 0)      p[8*k +: 8] = 8'hAA;
            else if (k == 1) p[8*k +: 8] = 8'h55;
            else             p[8*k +: 8] = seed + 8'(16 * k);
        end
        return p;
    endfunction

    task automatic pushFrame(input logic [PW-1:0] p);
        for (int k = 0; k < PB; k++) expQ.push_back(p[8*k +: 8]);
    endtask

    task automatic test_reset();
        int validSeen;
        rst = 1'b1; enable = 1'b0; send_req = 1'b0; tx_ready = 1'b0; packet = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        expFrames = 0; expOverrun = 0;
        @(negedge clk);
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (frames_sent !== 16'd0) begin errors++; $display("[TB] FAIL reset_frames_sent got=%0d exp=0", frames_sent); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_overrun got=%0d exp=0", overrun_cnt); end
        validSeen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0) validSeen++;
        end
        checks++; if (validSeen != 0) begin errors++; $display("[TB] FAIL idle_no_valid got=%0d exp=0 cycles", validSeen); end
    endtask

    task automatic test_single_frame();
        logic [PW-1:0] p;
        logic [7:0] e, g;
        p = makePkt(8'hF0);
        packet = p; tx_ready = 1'b1;
        pushFrame(p);
        expFrames++;
        @(posedge clk); #1 send_req = 1'b1;
        @(posedge clk); #1 send_req = 1'b0;
        for (int i = 0; i <= PB; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++; if (tx_data !== 8'hAA) begin errors++; $display("[TB] FAIL single_first_byte got=%h exp=AA", tx_data); end
            end
            if (i < PB) begin
                checks++;
                if (tx_valid !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0) begin
                    errors++; $display("[TB] FAIL single_active cyc=%0d valid/busy/done got=%b%b%b exp=110", i+1, tx_valid, busy, frame_done);
                end
            end else begin
                checks++;
                if (tx_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b1) begin
                    errors++; $display("[TB] FAIL single_done cyc=%0d valid/busy/done got=%b%b%b exp=001", i+1, tx_valid, busy, frame_done);
                end
                checks++; if (frames_sent !== 16'(expFrames)) begin errors++; $display("[TB] FAIL single_frames got=%0d exp=%0d", frames_sent, expFrames); end
            end
            if (i < PB) @(posedge clk);
        end
        @(negedge clk);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse got=%b exp=0", frame_done); end
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL single_count got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        while (expQ.size() > 0 && gotQ.size() > 0) begin
            e = expQ.pop_front(); g = gotQ.pop_front();
            checks++; if (g !== e) begin errors++; $display("[TB] FAIL single_byte got=%h exp=%h", g, e); end
        end
        expQ.delete(); gotQ.delete();
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] p;
        logic [3:0] patt;
        logic [7:0] prevData, e, g;
        logic stallPrev, done;
        patt = 4'b1001;
        p = makePkt(8'h07);
        packet = p; tx_ready = 1'b1;
        pushFrame(p);
        expFrames++;
        @(posedge clk); #1 send_req = 1'b1;
        @(posedge clk); #1 send_req = 1'b0;
        packet = '1;
        tx_ready = patt[0];
        stallPrev = 1'b0; done = 1'b0; prevData = 8'h00;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (stallPrev) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prevData) begin
                    errors++; $display("[TB] FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", c, tx_valid, tx_data, prevData);
                end
            end
            stallPrev = tx_valid && !tx_ready;
            prevData  = tx_data;
            if (frame_done === 1'b1) done = 1'b1;
            else begin
                @(posedge clk); #1 tx_ready = patt[(c + 1) % 4];
            end
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL bp_timeout got=no_frame_done exp=frame_done"); end
        checks++; if (frames_sent !== 16'(expFrames)) begin errors++; $display("[TB] FAIL bp_frames got=%0d exp=%0d", frames_sent, expFrames); end
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL bp_count got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        while (expQ.size() > 0 && gotQ.size() > 0) begin
            e = expQ.pop_front(); g = gotQ.pop_front();
            checks++; if (g !== e) begin errors++; $display("[TB] FAIL bp_byte got=%h exp=%h", g, e); end
        end
        expQ.delete(); gotQ.delete();
        tx_ready = 1'b1;
    endtask

    task automatic test_periodic();
        logic [PW-1:0] p;
        logic [7:0] e, g;
        p = makePkt(8'h3C);
        packet = p; tx_ready = 1'b1;
        repeat (10) pushFrame(p);
        expFrames += 10;
        @(posedge clk); #1 enable = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            if (n == 400) #1 enable = 1'b0;
            @(negedge clk);
            if (n == 39) begin
                checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL per_no_early_tick got=%b exp=0", tx_valid); end
            end
            if (n == 40) begin
                checks++; if (tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL per_first_tick got=%b exp=1", tx_valid); end
            end
        end
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++; if (frames_sent !== 16'(expFrames)) begin errors++; $display("[TB] FAIL per_frames got=%0d exp=%0d", frames_sent, expFrames); end
        checks++; if (overrun_cnt !== 8'(expOverrun)) begin errors++; $display("[TB] FAIL per_overrun got=%0d exp=%0d", overrun_cnt, expOverrun); end
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL per_count got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        while (expQ.size() > 0 && gotQ.size() > 0) begin
            e = expQ.pop_front(); g = gotQ.pop_front();
            checks++; if (g !== e) begin errors++; $display("[TB] FAIL per_byte got=%h exp=%h", g, e); end
        end
        expQ.delete(); gotQ.delete();
    endtask

    task automatic test_overrun();
        logic [PW-1:0] p;
        logic [7:0] e, g;
        p = makePkt(8'h5A);
        packet = p;
        // Ready only before edges that are multiples of 4: a frame takes 88 cycles,
        // so starts land on ticks 40,160,280,400 and ticks 80,120,200,240,320,360 drop.
        repeat (4) pushFrame(p);
        @(posedge clk); #1 enable = 1'b1; tx_ready = 1'b0;
        for (int n = 1; n <= 520; n++) begin
            @(posedge clk);
            #1 tx_ready = ((n % 4) == 3);
            if (n == 400) enable = 1'b0;
            if (n == 130) begin
                @(negedge clk);
                checks++; if (overrun_cnt !== 8'(expOverrun + 2)) begin errors++; $display("[TB] FAIL ovr_mid_cnt got=%0d exp=%0d", overrun_cnt, expOverrun + 2); end
                checks++; if (frames_sent !== 16'(expFrames + 1)) begin errors++; $display("[TB] FAIL ovr_mid_frames got=%0d exp=%0d", frames_sent, expFrames + 1); end
            end
        end
        expFrames += 4; expOverrun += 6;
        @(negedge clk);
        checks++; if (frames_sent !== 16'(expFrames)) begin errors++; $display("[TB] FAIL ovr_frames got=%0d exp=%0d", frames_sent, expFrames); end
        checks++; if (overrun_cnt !== 8'(expOverrun)) begin errors++; $display("[TB] FAIL ovr_cnt got=%0d exp=%0d", overrun_cnt, expOverrun); end

        // Stall one frame and hammer send_req to drive the counter into saturation
        tx_ready = 1'b0;
        pushFrame(p);
        @(posedge clk); #1 send_req = 1'b1;
        for (int k = 0; k <= 300; k++) begin
            @(posedge clk);
            if (k == 100) begin
                @(negedge clk);
                checks++; if (overrun_cnt !== 8'(expOverrun + 100)) begin errors++; $display("[TB] FAIL ovr_count_up got=%0d exp=%0d", overrun_cnt, expOverrun + 100); end
            end
        end
        @(negedge clk);
        expOverrun = 255;
        checks++; if (overrun_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL ovr_saturate got=%0d exp=255", overrun_cnt); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA) begin errors++; $display("[TB] FAIL ovr_stall_hold got=%b/%h exp=1/aa", tx_valid, tx_data); end
        send_req = 1'b0; tx_ready = 1'b1;
        expFrames++;
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++; if (frames_sent !== 16'(expFrames)) begin errors++; $display("[TB] FAIL ovr_sat_frames got=%0d exp=%0d", frames_sent, expFrames); end
        checks++; if (overrun_cnt !== 8'(expOverrun)) begin errors++; $display("[TB] FAIL ovr_sat_hold got=%0d exp=%0d", overrun_cnt, expOverrun); end
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL ovr_count got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        while (expQ.size() > 0 && gotQ.size() > 0) begin
            e = expQ.pop_front(); g = gotQ.pop_front();
            checks++; if (g !== e) begin errors++; $display("[TB] FAIL ovr_byte got=%h exp=%h", g, e); end
        end
        expQ.delete(); gotQ.delete();
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] p;
        logic [7:0] e, g;
        p = makePkt(8'h81);
        packet = p; tx_ready = 1'b1;
        for (int k = 0; k <= 10; k++) expQ.push_back(p[8*k +: 8]);
        @(posedge clk); #1 send_req = 1'b1;
        @(posedge clk); #1 send_req = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        expFrames = 0; expOverrun = 0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_abort got=%b%b exp=00", tx_valid, busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done got=%b exp=0", frame_done); end
        checks++; if (frames_sent !== 16'd0) begin errors++; $display("[TB] FAIL rmid_frames got=%0d exp=0", frames_sent); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rmid_overrun got=%0d exp=0", overrun_cnt); end
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL rmid_partial_count got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        while (expQ.size() > 0 && gotQ.size() > 0) begin
            e = expQ.pop_front(); g = gotQ.pop_front();
            checks++; if (g !== e) begin errors++; $display("[TB] FAIL rmid_partial_byte got=%h exp=%h", g, e); end
        end
        expQ.delete(); gotQ.delete();

        pushFrame(p);
        expFrames++;
        @(posedge clk); #1 send_req = 1'b1;
        @(posedge clk); #1 send_req = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA) begin errors++; $display("[TB] FAIL rmid_restart got=%b/%h exp=1/aa", tx_valid, tx_data); end
        repeat (25) @(posedge clk);
        @(negedge clk);
        checks++; if (frames_sent !== 16'(expFrames)) begin errors++; $display("[TB] FAIL rmid_frames_after got=%0d exp=%0d", frames_sent, expFrames); end
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL rmid_count got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        while (expQ.size() > 0 && gotQ.size() > 0) begin
            e = expQ.pop_front(); g = gotQ.pop_front();
            checks++; if (g !== e) begin errors++; $display("[TB] FAIL rmid_byte got=%h exp=%h", g, e); end
        end
        expQ.delete(); gotQ.delete();
    endtask

    // Run every scenario in order, then report
    initial begin
        rst = 1'b1; enable = 1'b0; send_req = 1'b0; tx_ready = 1'b0; packet = '0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_periodic();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/packet_tx_sched.md
Name: packet_tx_sched

Overview:
Frame-rate scheduler for the game-state packet: the 176-bit packet (header 0x55AA, player x/y, three wave y/bitfield records) is assembled continuously upstream. On each frame tick or software request, this block snapshots the packet and streams it byte-by-byte to the serial transmitter over a valid/ready handshake. It tracks completed frames and frames dropped while a transfer was still in flight.

Parameters:
PACKET_BYTES, 22, bytes per packet; packet width is 8*PACKET_BYTES.
PERIOD_CYCLES, 1666666, clk cycles between frame ticks (60 Hz at 100 MHz); minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  1 = period counter runs and ticks are generated
send_req  input  1  single-cycle pulse requesting an immediate packet
packet  input  8*PACKET_BYTES  assembled packet; byte k = packet[8k+7:8k]
tx_data  output  8  current byte to transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte when high with tx_valid
busy  output  1  1 while a packet transfer is in progress
frame_done  output  1  one-cycle pulse after the last byte is accepted
frames_sent  output  16  completed packets, wraps at 0xFFFF -> 0
overrun_cnt  output  8  dropped triggers, saturates at 0xFF

Behaviour:
- Reset (sync, rst=1 at a clk edge): tx_data=0, tx_valid=0, busy=0, frame_done=0, frames_sent=0, overrun_cnt=0, period counter=0, state IDLE, byte index=0. rst overrides all other inputs. Reset mid-transfer aborts the transfer: tx_valid=0 from the following cycle, and the partial frame is not counted.
- Period counter: counts 0..PERIOD_CYCLES-1 while enable=1, then wraps to 0. tick=1 in the cycle where count==PERIOD_CYCLES-1 and enable=1. When enable=0, the counter is held at 0 and no ticks occur. A send_req is still honoured when enable=0.
- trigger = tick OR send_req. A coincident tick and send_req form one trigger.
- States: IDLE, SEND.
- IDLE:
  - On trigger, capture packet into the internal snapshot register at that edge, go to SEND, and set busy=1, tx_valid=1, tx_data=byte 0. The first byte is valid in the cycle after the trigger (latency 1).
  - Packet input changes after the capture edge do not affect the frame.
- SEND:
  - A byte transfers at each edge with tx_valid=1 and tx_ready=1.
  - tx_data and tx_valid hold stable while tx_ready=0, with no timeout.
  - After a transfer of byte k<PACKET_BYTES-1, tx_data=byte k+1 with tx_valid=1 on the next cycle (no bubble; full rate when tx_ready is held high).
  - On transfer of byte PACKET_BYTES-1:
    - next cycle: tx_valid=0, busy=0, frame_done=1 for one cycle;
    - frames_sent increments;
    - state returns to IDLE.
  - A trigger in the cycle of that final transfer is an overrun.
  - A trigger in IDLE on the frame_done cycle starts a new packet.
- Overrun: a trigger while in SEND is dropped and overrun_cnt increments, saturating at 255. The in-flight transfer is unaffected.
- enable falling mid-transfer does not stop the current packet.
- Byte order: byte 0 first (little-endian). The header therefore appears on the wire as 0xAA then 0x55, followed by player_x, player_y, wave0_y, then the wave0 bitfield as 5 bytes LSB first, and so on for waves 1 and 2.
- Minimum frame duration: PACKET_BYTES+1 cycles from trigger to frame_done.

Test Plan:
- Reset/idle: PERIOD_CYCLES=40, enable=0, rst pulse -> all outputs 0. No tx_valid over 200 cycles.
- Single frame, tx_ready=1:
  - stimulus: packet={40'h1111111111,8'h33,…,8'h20,8'h10,16'h55AA}, send_req pulse at cycle T.
  - response: tx_valid high T+1..T+22; bytes AA,55,10,20,…; frame_done at T+23; frames_sent=1; busy high T+1..T+22.
- Backpressure: tx_ready toggling 1,0,0,1 pattern. Packet input changes to all 0xFF after the capture edge -> tx_data held stable while ready=0, original bytes sent in order, 22 transfers exactly.
- Periodic ticks: PERIOD_CYCLES=40, enable=1, tx_ready=1 for 400 cycles -> triggers every 40 cycles, frames_sent=10, overrun_cnt=0.
- Overrun: PERIOD_CYCLES=40, tx_ready high 1 cycle in 4 (88+ cycles per frame) -> alternate ticks dropped. overrun_cnt increments per dropped tick and saturates at 255 on a long run. frames_sent counts only completed frames.
- Reset mid-transfer: rst asserted after byte 10 accepted -> tx_valid=0 next cycle, frames_sent stays 0. A next send_req produces a full frame starting at 0xAA.
